spi_regfile_peripheral: RTL and testbench



---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_regfile_peripheral.sv | 162 ++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-file target.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_state_t;

    localparam logic SPI_RW_WRITE = 1'b1;

    function automatic int unsigned spi_frame_width(input int unsigned addr_w,
                                                    input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with single-cycle edge pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI target exposing NUM_REGS x DATA_W control registers with write and read-back.
module spi_regfile_peripheral
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned CPOL     = 0,
    parameter int unsigned CPHA     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_sclk,
    input  logic                       spi_cs_n,
    input  logic                       spi_mosi,
    output logic                       spi_miso,
    output logic                       spi_miso_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int unsigned FRAME_W = spi_frame_width(ADDR_W, DATA_W);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned CMD_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_W - 1);
    // MISO only advances once the first data bit has been sampled.
    localparam logic [CNT_W-1:0] SHIFT_MIN = CNT_W'(ADDR_W + 2);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic mosi_meta, mosi_s;
    logic lead_edge, trail_edge, sample_edge, shift_edge;

    spi_state_t         state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CMD_W-1:0]   cmd_sr, cmd_next;
    logic [DATA_W-1:0]  data_sr, data_next, shift_out, rd_word;
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic               is_write, addr_ok;

    spi_sync_edge #(.RST_VAL(CPOL != 0)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= spi_mosi;
            mosi_s    <= mosi_meta;
        end
    end

    assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
    assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

    assign cmd_next  = (cmd_sr << 1) | CMD_W'(mosi_s);
    assign data_next = (data_sr << 1) | DATA_W'(mosi_s);
    assign is_write  = (cmd_sr[ADDR_W] == SPI_RW_WRITE);
    assign addr_ok   = (32'(cmd_sr[ADDR_W-1:0]) < NUM_REGS);

    // Out-of-range read addresses return zero.
    always_comb begin
        rd_word = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (32'(cmd_next[ADDR_W-1:0]) == k) begin
                rd_word = regs[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            data_sr   <= '0;
            shift_out <= '0;
            regs      <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        state   <= CMD;
                    end
                end
                CMD: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sample_edge) begin
                        cmd_sr  <= cmd_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CMD_LAST) begin
                            shift_out <= rd_word;
                            state     <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sample_edge) begin
                        data_sr <= data_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == DATA_LAST) begin
                            state <= DONE;
                            if (!addr_ok) begin
                                frame_err <= 1'b1;
                            end else if (is_write) begin
                                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                                    if (32'(cmd_sr[ADDR_W-1:0]) == k) begin
                                        regs[k*DATA_W +: DATA_W] <= data_next;
                                    end
                                end
                                wr_strobe <= 1'b1;
                                wr_addr   <= cmd_sr[ADDR_W-1:0];
                            end
                        end
                    end else if (shift_edge && bit_cnt >= SHIFT_MIN) begin
                        shift_out <= shift_out << 1;
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign spi_miso_oe = (state == DATA) && !is_write;
    assign spi_miso    = spi_miso_oe ? shift_out[DATA_W-1] : 1'b0;
    assign regs_flat   = regs;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench: four SPI modes on one shared bus plus a wide-configuration instance.
module tb_spi_regfile_peripheral;

    localparam int H = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk_p = 1'b0;
    logic cs_n = 1'b1;
    logic cs_w = 1'b1;
    logic mosi = 1'b0;

    logic        miso [5];
    logic        oe   [5];
    logic        wr   [5];
    logic        fe   [5];
    logic [39:0] regs [4];
    logic [6:0]  wa   [4];
    logic [255:0] regs_w;
    logic [3:0]   wa_w;

    int wr_cnt [5];
    int fe_cnt [5];
    int wr_base [5];
    int fe_base [5];
    logic [7:0] rd [4];
    int oe_cnt [4];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        spi_regfile_peripheral #(
            .NUM_REGS (5),
            .DATA_W   (8),
            .ADDR_W   (7),
            .CPOL     (m / 2),
            .CPHA     (m % 2)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .spi_sclk    ((m >= 2) ? ~sclk_p : sclk_p),
            .spi_cs_n    (cs_n),
            .spi_mosi    (mosi),
            .spi_miso    (miso[m]),
            .spi_miso_oe (oe[m]),
            .regs_flat   (regs[m]),
            .wr_strobe   (wr[m]),
            .wr_addr     (wa[m]),
            .frame_err   (fe[m])
        );
    end

    spi_regfile_peripheral #(
        .NUM_REGS (16),
        .DATA_W   (16),
        .ADDR_W   (4),
        .CPOL     (0),
        .CPHA     (0)
    ) u_wide (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (sclk_p),
        .spi_cs_n    (cs_w),
        .spi_mosi    (mosi),
        .spi_miso    (miso[4]),
        .spi_miso_oe (oe[4]),
        .regs_flat   (regs_w),
        .wr_strobe   (wr[4]),
        .wr_addr     (wa_w),
        .frame_err   (fe[4])
    );

    always @(posedge clk) begin
        for (int m = 0; m < 5; m++) begin
            if (wr[m] === 1'b1) wr_cnt[m] <= wr_cnt[m] + 1;
            if (fe[m] === 1'b1) fe_cnt[m] <= fe_cnt[m] + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic rw, input logic [6:0] a, input logic [7:0] d);
        return {rw, a, d, 16'h0000};
    endfunction

    function automatic logic [31:0] mkw(input logic rw, input logic [3:0] a, input logic [15:0] d);
        return {rw, a, d, 11'h000};
    endfunction

    task automatic snap();
        for (int m = 0; m < 5; m++) begin
            wr_base[m] = wr_cnt[m];
            fe_base[m] = fe_cnt[m];
        end
    endtask

    // Controller-side MISO capture at each mode's own sample edge.
    task automatic sample_miso(input int phase, input int i);
        for (int m = 0; m < 4; m++) begin
            if ((m % 2) == phase) begin
                if (i >= 8 && i < 16) rd[m] = {rd[m][6:0], miso[m]};
                if (oe[m] === 1'b1) oe_cnt[m]++;
            end
        end
    endtask

    task automatic frame(input logic wide, input logic [31:0] bits, input int n,
                         input logic end_cs);
        for (int m = 0; m < 4; m++) begin
            rd[m] = 8'h00;
            oe_cnt[m] = 0;
        end
        if (wide) cs_w = 1'b0;
        else cs_n = 1'b0;
        #(2 * H);
        for (int i = 0; i < n; i++) begin
            mosi = bits[31-i];
            #H;
            sample_miso(0, i);
            sclk_p = 1'b1;
            #H;
            sample_miso(1, i);
            sclk_p = 1'b0;
            #H;
        end
        #(2 * H);
        if (end_cs) begin
            cs_n = 1'b1;
            cs_w = 1'b1;
        end
        #(4 * H);
    endtask

    task automatic chk_counts(input string tag, input int exp_wr, input int exp_fe);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("%s wr m%0d", tag, m), 256'(wr_cnt[m] - wr_base[m]), 256'(exp_wr));
            chk($sformatf("%s err m%0d", tag, m), 256'(fe_cnt[m] - fe_base[m]), 256'(exp_fe));
        end
    endtask

    task automatic chk_regs(input string tag, input logic [39:0] exp);
        for (int m = 0; m < 4; m++) chk($sformatf("%s regs m%0d", tag, m), 256'(regs[m]), 256'(exp));
    endtask

    task automatic chk_read(input string tag, input logic [7:0] exp);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("%s miso m%0d", tag, m), 256'(rd[m]), 256'(exp));
            chk($sformatf("%s oe m%0d", tag, m), 256'(oe_cnt[m]), 256'(8));
        end
    endtask

    initial begin
        #50;
        @(negedge clk);
        chk("rst regs", 256'(regs[0]), 256'(0));
        chk("rst miso", 256'(miso[0]), 256'(0));
        chk("rst oe", 256'(oe[0]), 256'(0));
        chk("rst wr", 256'(wr[0]), 256'(0));
        chk("rst waddr", 256'(wa[0]), 256'(0));
        chk("rst err", 256'(fe[0]), 256'(0));
        chk("rst wide regs", regs_w, 256'(0));
        rst = 1'b0;
        #(4 * H);

        // Write 0xA5 to register 2
        snap();
        frame(1'b0, mk(1'b1, 7'd2, 8'hA5), 16, 1'b1);
        chk_regs("wr2", 40'h00_00_A5_00_00);
        chk_counts("wr2", 1, 0);
        chk("wr2 waddr", 256'(wa[0]), 256'(2));

        // Write 0x3C to register 4, then read it back in every mode
        snap();
        frame(1'b0, mk(1'b1, 7'd4, 8'h3C), 16, 1'b1);
        chk_regs("wr4", 40'h3C_00_A5_00_00);
        snap();
        frame(1'b0, mk(1'b0, 7'd4, 8'h00), 16, 1'b1);
        chk_read("rd4", 8'h3C);
        chk_counts("rd4", 0, 0);
        chk("rd4 oe idle", 256'(oe[0]), 256'(0));

        // Invalid address 9
        snap();
        frame(1'b0, mk(1'b1, 7'd9, 8'hFF), 16, 1'b1);
        chk_regs("wr9", 40'h3C_00_A5_00_00);
        chk_counts("wr9", 0, 1);
        snap();
        frame(1'b0, mk(1'b0, 7'd9, 8'h00), 16, 1'b1);
        chk_read("rd9", 8'h00);
        chk_counts("rd9", 0, 1);

        // Abort after 10 bits, then a complete frame
        snap();
        frame(1'b0, mk(1'b1, 7'd1, 8'h77), 10, 1'b1);
        chk_regs("abort", 40'h3C_00_A5_00_00);
        chk_counts("abort", 0, 1);
        snap();
        frame(1'b0, mk(1'b1, 7'd1, 8'h5A), 16, 1'b1);
        chk_regs("wr1", 40'h3C_00_A5_5A_00);
        chk_counts("wr1", 1, 0);

        // Over-clocking: 20 SCLKs on a 16-bit frame
        snap();
        frame(1'b0, mk(1'b1, 7'd3, 8'h11), 20, 1'b1);
        chk_regs("ovr", 40'h3C_11_A5_5A_00);
        chk_counts("ovr", 1, 0);
        chk("ovr waddr", 256'(wa[1]), 256'(3));

        // Wide configuration
        snap();
        frame(1'b1, mkw(1'b1, 4'd15, 16'hBEEF), 21, 1'b1);
        chk("wide top", 256'(regs_w[255:240]), 256'(16'hBEEF));
        chk("wide rest", 256'(regs_w[239:0]), 256'(0));
        chk("wide wr", 256'(wr_cnt[4] - wr_base[4]), 256'(1));
        chk("wide waddr", 256'(wa_w), 256'(15));
        chk_regs("wide narrow", 40'h3C_11_A5_5A_00);

        // Reset mid-frame, then confirm the next frame is accepted
        frame(1'b0, mk(1'b1, 7'd0, 8'hFF), 10, 1'b0);
        rst = 1'b1;
        #20;
        chk_regs("midrst", 40'h0);
        chk("midrst waddr", 256'(wa[0]), 256'(0));
        chk("midrst miso", 256'(miso[0]), 256'(0));
        chk("midrst oe", 256'(oe[0]), 256'(0));
        chk("midrst wide", regs_w, 256'(0));
        cs_n = 1'b1;
        #40;
        rst = 1'b0;
        #(4 * H);
        snap();
        frame(1'b0, mk(1'b1, 7'd0, 8'h42), 16, 1'b1);
        chk_regs("post rst", 40'h00_00_00_00_42);
        chk_counts("post rst", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
